// File: rtl/mem_refill_responder.sv
// mem_refill_responder
//   Memory-side responder for the data-cache fill interface. Accepts one
//   word read or write at a time, waits a fixed LATENCY cycles and then
//   presents a registered response that is held until the initiator takes it.
//
// Ports
//   clk, rst_n       clock and asynchronous active-low reset
//   req_valid        initiator presents a request
//   req_ready        responder is idle and can accept (decoded from state only)
//   req_we           1 = write, 0 = read
//   req_addr         byte address; bits [1:0] are ignored
//   req_wdata        write data
//   req_be           byte enables for writes, bit i covers bits [8i+7:8i]
//   resp_valid       response available (registered)
//   resp_ready       initiator accepts the response
//   resp_rdata       read data, zero for write responses (registered)
//   resp_we          echo of the answered request's req_we (registered)
module mem_refill_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_we
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic                    we_r;
  logic [IDX_W-1:0]        idx_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [3:0]              be_r;
  logic                    resp_valid_r;
  logic [DATA_WIDTH-1:0]   resp_rdata_r;
  logic                    resp_we_r;
  logic                    req_ready_s;
  logic                    access_s;
  logic                    unused_addr_s;

  // Word storage; deliberately outside the reset domain so contents survive reset.
  logic [DATA_WIDTH-1:0]   mem_r [WORDS];

  // Byte-lane merge of new write data into an existing word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [3:0]            be
  );
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

  // Byte offset bits carry no information for a word-addressed array.
  assign unused_addr_s = ^req_addr[1:0];

  // Ready decode and access strobe, both from registered state only.
  always_comb begin
    req_ready_s = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready_s = 1'b1;
        access_s    = 1'b0;
      end
      ST_WAIT: begin
        req_ready_s = 1'b0;
        if (cnt_r == 4'd0) begin
          access_s = 1'b1;
        end else begin
          access_s = 1'b0;
        end
      end
      ST_RESP: begin
        req_ready_s = 1'b0;
        access_s    = 1'b0;
      end
      default: begin
        req_ready_s = 1'b0;
        access_s    = 1'b0;
      end
    endcase
  end

  // Array write port; commits on the same edge that raises resp_valid.
  // An async reset forces state to IDLE, so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (access_s && we_r) begin
      mem_r[idx_r] <= merge_bytes(mem_r[idx_r], wdata_r, be_r);
    end
  end

  // Request/response FSM with latency counter and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      we_r         <= 1'b0;
      idx_r        <= {IDX_W{1'b0}};
      wdata_r      <= {DATA_WIDTH{1'b0}};
      be_r         <= 4'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {DATA_WIDTH{1'b0}};
      resp_we_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r    <= req_we;
            idx_r   <= req_addr[ADDR_WIDTH-1:2];
            wdata_r <= req_wdata;
            be_r    <= req_be;
            cnt_r   <= 4'(LATENCY - 1);
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            if (we_r) begin
              resp_rdata_r <= {DATA_WIDTH{1'b0}};
            end else begin
              resp_rdata_r <= mem_r[idx_r];
            end
            resp_valid_r <= 1'b1;
            resp_we_r    <= we_r;
            state_r      <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          // A new req_valid here is ignored; acceptance only happens from IDLE.
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_we    = resp_we_r;

endmodule

// File: doc/mem_refill_responder.md
Name: mem_refill_responder

Overview:
- Memory-side responder for the data-cache miss/refill path. It is the far end of the cache's fill interface: the cache (initiator) issues word read and write requests, and this block returns data after a fixed, parameterised latency.
- Internally it holds a word-addressed data array and a small FSM with a latency counter. It gives the pipeline a realistic multi-cycle memory to stall against.

Parameters:
- DATA_WIDTH, 32, data word width in bits; must be 32.
- ADDR_WIDTH, 17, byte-address width; the array holds 2^(ADDR_WIDTH-2) words.
- LATENCY, 3, number of cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored, word index = req_addr[ADDR_WIDTH-1:2].
- req_wdata  input  DATA_WIDTH  write data.
- req_be  input  4  byte enables for writes; bit i enables bits [8i+7:8i]; ignored for reads.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  DATA_WIDTH  read data; 0 for write responses.
- resp_we  output  1  echoes req_we of the request being answered.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_we = 0, latched request fields = 0.
- The data array is not reset. Its contents are preserved across reset. Simulation initialises it to all zeros.
- States:
  - IDLE: req_ready = 1. When req_valid & req_ready at an edge, latch we/addr/wdata/be, load counter = LATENCY-1, go to WAIT.
  - WAIT: req_ready = 0. At each edge:
    - If counter == 0: perform the access and go to RESP.
    - Otherwise: decrement the counter.
    - Access for a read: resp_rdata <= array[idx].
    - Access for a write: array[idx] bytes with be=1 <= wdata bytes, resp_rdata <= 0.
    - On the same edge set resp_valid <= 1 and resp_we <= latched we.
  - RESP: req_ready = 0; resp_valid = 1. resp_rdata and resp_we stay stable. At an edge with resp_ready = 1: resp_valid <= 0 and go to IDLE. Otherwise hold indefinitely.
- Timing: a request accepted at edge T gets resp_valid high from edge T+LATENCY. If resp_ready is held high, req_ready is high again after edge T+LATENCY+1. Minimum issue interval is LATENCY+1 cycles.
- req_ready is a combinational decode of state only; it never depends on req_valid. resp_valid, resp_rdata and resp_we are registered.
- Memory commit point: writes commit at the edge that raises resp_valid, never at acceptance. A read accepted after a write's response handshake returns the written data.
- Request inputs are don't-care outside acceptance. Changes to them while in WAIT/RESP have no effect.
- req_be = 0 on a write: array unchanged; a response is still generated.
- Address wrap: only the index bits are used. Aliasing above 2^ADDR_WIDTH is not possible because the port width bounds it.
- Reset mid-operation:
  - Reset in WAIT aborts the request. A pending write is not committed and no response is produced.
  - Reset in RESP drops the response.
- Simultaneous resp handshake and new req_valid in RESP: the response completes. The new request is not accepted until the following cycle in IDLE.

Test Plan:
- Reset then read: rst_n low 2 cycles, read addr 0x00010 at edge T, resp_ready=1 -> req_ready low from T, resp_valid at T+3, resp_rdata=0x00000000, resp_we=0, req_ready high after T+4.
- Write then read, LATENCY=3: write 0xDEADBEEF, be=4'hF, addr 0x00020; complete the handshake; read 0x00022 -> resp_rdata=0xDEADBEEF, with resp_valid exactly 3 cycles after each acceptance.
- Partial write: a prior word 0x11223344 at 0x00040, write 0xAABBCCDD with be=4'b0101 -> subsequent read returns 0x11BB33DD; with be=4'b0000 the read returns 0x11223344.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid with req_valid=1 throughout -> resp_valid and resp_rdata constant, req_ready=0, no second acceptance; one cycle after resp_ready=1, req_ready=1.
- Reset mid-write: accept a write of 0xCAFEF00D to 0x00080, pulse rst_n low one cycle later (in WAIT) -> resp_valid never rises; a later read of 0x00080 returns the old value (0x00000000).
- LATENCY=1 build: back-to-back reads with resp_ready=1 -> resp_valid one cycle after each acceptance; acceptances spaced 2 cycles apart.
